// File: rtl/ysyx_24090003_wbu_pipe_pkg.sv
// ysyx_24090003_wbu_pipe_pkg: writeback-source and load-size encodings shared by the WBU.
// Revision: 1.0
`default_nettype none

package ysyx_24090003_wbu_pipe_pkg;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
  localparam logic [1:0] WB_SEL_CSR = 2'd3;

  localparam logic [1:0] LD_SIZE_B  = 2'd0;
  localparam logic [1:0] LD_SIZE_H  = 2'd1;
  localparam logic [1:0] LD_SIZE_W  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/ysyx_24090003_regfile_param.sv
// ysyx_24090003_regfile_param: 2R/1W register file, hardwired x0, write-through bypass.
// Revision: 1.0
`default_nettype none

module ysyx_24090003_regfile_param #(
  parameter  int XLEN    = 32,
  parameter  int NR_REGS = 32,
  localparam int AW      = $clog2(NR_REGS)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr1,
  input  logic [AW-1:0]   i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] regs_q [NR_REGS];
  logic            w_we_eff;

  assign w_we_eff = i_we && (i_waddr != '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NR_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (w_we_eff) begin
      regs_q[i_waddr] <= i_wdata;
    end
  end

  // A read of the address being written this cycle sees the new value.
  function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] addr);
    if (addr == '0)
      return '0;
    else if (w_we_eff && (addr == i_waddr))
      return i_wdata;
    else
      return regs_q[addr];
  endfunction

  always_comb begin
    o_rdata1 = rd_port(i_raddr1);
    o_rdata2 = rd_port(i_raddr2);
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_24090003_wbu_pipe.sv
// ysyx_24090003_wbu_pipe: one-entry writeback stage with load formatting, forwarding and regfile.
// Revision: 1.0
`default_nettype none

module ysyx_24090003_wbu_pipe
  import ysyx_24090003_wbu_pipe_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int NR_REGS = 32,
  localparam int AW      = $clog2(NR_REGS)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_next_pc,
  input  logic [AW-1:0]   i_rd_addr,
  input  logic            i_reg_wen,
  input  logic [1:0]      i_wb_sel,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [XLEN-1:0] i_mem_rdata,
  input  logic [XLEN-1:0] i_csr_rdata,
  input  logic [1:0]      i_ld_size,
  input  logic            i_ld_unsigned,
  input  logic [1:0]      i_addr_lo,
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic            o_fwd_valid,
  output logic [AW-1:0]   o_fwd_addr,
  output logic [XLEN-1:0] o_fwd_data,
  output logic            o_commit_valid,
  input  logic            i_commit_ready,
  output logic [XLEN-1:0] o_commit_pc,
  output logic [XLEN-1:0] o_commit_next_pc,
  output logic [XLEN-1:0] o_rd_wdata
);

  logic            full_q,    full_d;
  logic [XLEN-1:0] pc_q,      pc_d;
  logic [XLEN-1:0] npc_q,     npc_d;
  logic [XLEN-1:0] data_q,    data_d;
  logic [AW-1:0]   rd_q,      rd_d;
  logic            wen_q,     wen_d;

  logic            w_accept;
  logic            w_commit;
  logic [XLEN-1:0] w_fmt;

  // Halfword at offset 3 would straddle the word; it is pinned to offset 2.
  function automatic logic [XLEN-1:0] fmt_load(
    input logic [XLEN-1:0] mem,
    input logic [1:0]      size,
    input logic            uns,
    input logic [1:0]      lo
  );
    logic [1:0]      off;
    logic [XLEN-1:0] sh;
    off = ((size == LD_SIZE_H) && (lo == 2'd3)) ? 2'd2 : lo;
    sh  = mem >> {off, 3'b000};
    case (size)
      LD_SIZE_B: return uns ? {{(XLEN-8){1'b0}}, sh[7:0]}
                            : {{(XLEN-8){sh[7]}}, sh[7:0]};
      LD_SIZE_H: return uns ? {{(XLEN-16){1'b0}}, sh[15:0]}
                            : {{(XLEN-16){sh[15]}}, sh[15:0]};
      default:   return mem;
    endcase
  endfunction

  always_comb begin
    w_fmt = i_alu_result;
    case (i_wb_sel)
      WB_SEL_ALU: w_fmt = i_alu_result;
      WB_SEL_MEM: w_fmt = fmt_load(i_mem_rdata, i_ld_size, i_ld_unsigned, i_addr_lo);
      WB_SEL_PC4: w_fmt = i_pc + XLEN'(4);
      WB_SEL_CSR: w_fmt = i_csr_rdata;
      default:    w_fmt = i_alu_result;
    endcase
  end

  assign o_commit_valid = full_q;
  assign w_commit       = full_q && i_commit_ready;
  assign o_ready        = !full_q || i_commit_ready;
  assign w_accept       = i_valid && o_ready;

  always_comb begin
    full_d = full_q;
    pc_d   = pc_q;
    npc_d  = npc_q;
    data_d = data_q;
    rd_d   = rd_q;
    wen_d  = wen_q;
    if (w_accept) begin
      full_d = 1'b1;
      pc_d   = i_pc;
      npc_d  = i_next_pc;
      data_d = w_fmt;
      rd_d   = i_rd_addr;
      wen_d  = i_reg_wen;
    end else if (w_commit) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      full_q <= 1'b0;
      pc_q   <= '0;
      npc_q  <= '0;
      data_q <= '0;
      rd_q   <= '0;
      wen_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      pc_q   <= pc_d;
      npc_q  <= npc_d;
      data_q <= data_d;
      rd_q   <= rd_d;
      wen_q  <= wen_d;
    end
  end

  assign o_commit_pc      = pc_q;
  assign o_commit_next_pc = npc_q;
  assign o_rd_wdata       = data_q;
  assign o_fwd_valid      = full_q && wen_q && (rd_q != '0);
  assign o_fwd_addr       = rd_q;
  assign o_fwd_data       = data_q;

  ysyx_24090003_regfile_param #(
    .XLEN    (XLEN),
    .NR_REGS (NR_REGS)
  ) u_regfile (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_we     (w_commit && wen_q),
    .i_waddr  (rd_q),
    .i_wdata  (data_q),
    .i_raddr1 (i_rs1_addr),
    .i_raddr2 (i_rs2_addr),
    .o_rdata1 (o_rs1_data),
    .o_rdata2 (o_rs2_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24090003_wbu_pipe.sv
// tb_ysyx_24090003_wbu_pipe: directed bench for the WBU stage (RV32I and RV32E instances).
// Revision: 1.0
`default_nettype none

module tb_ysyx_24090003_wbu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, ready;
  logic [31:0] pc, next_pc;
  logic [4:0]  rd_addr;
  logic        reg_wen;
  logic [1:0]  wb_sel;
  logic [31:0] alu, mem, csr;
  logic [1:0]  ld_size;
  logic        ld_uns;
  logic [1:0]  addr_lo;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        commit_valid, commit_ready;
  logic [31:0] commit_pc, commit_npc, rd_wdata;

  logic        e_valid, e_ready;
  logic [3:0]  e_rd_addr, e_rs1_addr, e_rs2_addr, e_fwd_addr;
  logic [31:0] e_rs1_data, e_rs2_data, e_fwd_data;
  logic        e_fwd_valid, e_commit_valid, e_commit_ready;
  logic [31:0] e_commit_pc, e_commit_npc, e_rd_wdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_24090003_wbu_pipe #(.XLEN(32), .NR_REGS(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
    .i_pc(pc), .i_next_pc(next_pc), .i_rd_addr(rd_addr), .i_reg_wen(reg_wen),
    .i_wb_sel(wb_sel), .i_alu_result(alu), .i_mem_rdata(mem), .i_csr_rdata(csr),
    .i_ld_size(ld_size), .i_ld_unsigned(ld_uns), .i_addr_lo(addr_lo),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .o_rs1_data(rs1_data), .o_rs2_data(rs2_data),
    .o_fwd_valid(fwd_valid), .o_fwd_addr(fwd_addr), .o_fwd_data(fwd_data),
    .o_commit_valid(commit_valid), .i_commit_ready(commit_ready),
    .o_commit_pc(commit_pc), .o_commit_next_pc(commit_npc), .o_rd_wdata(rd_wdata)
  );

  ysyx_24090003_wbu_pipe #(.XLEN(32), .NR_REGS(16)) dut_e (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(e_valid), .o_ready(e_ready),
    .i_pc(pc), .i_next_pc(next_pc), .i_rd_addr(e_rd_addr), .i_reg_wen(reg_wen),
    .i_wb_sel(wb_sel), .i_alu_result(alu), .i_mem_rdata(mem), .i_csr_rdata(csr),
    .i_ld_size(ld_size), .i_ld_unsigned(ld_uns), .i_addr_lo(addr_lo),
    .i_rs1_addr(e_rs1_addr), .i_rs2_addr(e_rs2_addr),
    .o_rs1_data(e_rs1_data), .o_rs2_data(e_rs2_data),
    .o_fwd_valid(e_fwd_valid), .o_fwd_addr(e_fwd_addr), .o_fwd_data(e_fwd_data),
    .o_commit_valid(e_commit_valid), .i_commit_ready(e_commit_ready),
    .o_commit_pc(e_commit_pc), .o_commit_next_pc(e_commit_npc), .o_rd_wdata(e_rd_wdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a rising edge; checks happen on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_fmt(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [1:0] lo, input logic [31:0] exp);
    valid = 1'b1; wb_sel = 2'd1; ld_size = sz; ld_uns = uns; addr_lo = lo;
    rd_addr = 5'd6; reg_wen = 1'b1;
    step();
    valid = 1'b0;
    @(negedge clk);
    check(tag, rd_wdata, exp);
    step();
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; pc = 32'h0; next_pc = 32'h0; rd_addr = 5'd0;
    reg_wen = 1'b0; wb_sel = 2'd0; alu = 32'h0; mem = 32'h0; csr = 32'h0;
    ld_size = 2'd2; ld_uns = 1'b0; addr_lo = 2'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    commit_ready = 1'b0;
    e_valid = 1'b0; e_rd_addr = 4'd0; e_rs1_addr = 4'd0; e_rs2_addr = 4'd0;
    e_commit_ready = 1'b1;

    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready",        {31'd0, ready},        32'd1);
    check("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
    check("rst_fwd_valid",    {31'd0, fwd_valid},    32'd0);
    check("rst_rd_wdata",     rd_wdata,              32'd0);
    check("rst_commit_pc",    commit_pc,             32'd0);
    check("rst_fwd_data",     fwd_data,              32'd0);

    // Backpressure: hold ALU result for three cycles.
    step();
    valid = 1'b1; wb_sel = 2'd0; alu = 32'hDEADBEEF; rd_addr = 5'd5; reg_wen = 1'b1;
    pc = 32'h0000_0100; next_pc = 32'h0000_0104; commit_ready = 1'b0; rs1_addr = 5'd5;
    step();
    valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_commit_valid", {31'd0, commit_valid}, 32'd1);
      check("bp_ready",        {31'd0, ready},        32'd0);
      check("bp_fwd_valid",    {31'd0, fwd_valid},    32'd1);
      check("bp_fwd_addr",     {27'd0, fwd_addr},     32'd5);
      check("bp_fwd_data",     fwd_data,              32'hDEADBEEF);
      check("bp_commit_npc",   commit_npc,            32'h0000_0104);
      check("bp_rs1_before",   rs1_data,              32'd0);
      step();
    end
    commit_ready = 1'b1;
    @(negedge clk);
    check("bp_bypass_rs1", rs1_data, 32'hDEADBEEF);
    check("bp_ready_commit", {31'd0, ready}, 32'd1);
    step();
    @(negedge clk);
    check("bp_rs1_after",    rs1_data,              32'hDEADBEEF);
    check("bp_commit_clear", {31'd0, commit_valid}, 32'd0);
    step();

    // Load formatting.
    mem = 32'h80FF7F01;
    load_fmt("ld_b1_s",  2'd0, 1'b0, 2'd1, 32'h0000007F);
    load_fmt("ld_b2_s",  2'd0, 1'b0, 2'd2, 32'hFFFFFFFF);
    load_fmt("ld_h2_u",  2'd1, 1'b1, 2'd2, 32'h000080FF);
    load_fmt("ld_h2_s",  2'd1, 1'b0, 2'd2, 32'hFFFF80FF);
    load_fmt("ld_w",     2'd2, 1'b0, 2'd0, 32'h80FF7F01);
    load_fmt("ld_h3_u",  2'd1, 1'b1, 2'd3, 32'h000080FF);
    load_fmt("ld_b3_u",  2'd0, 1'b1, 2'd3, 32'h00000080);
    rs2_addr = 5'd6;
    @(negedge clk);
    check("ld_x6", rs2_data, 32'h00000080);

    // Streaming: four back-to-back accepts.
    wb_sel = 2'd0; reg_wen = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      valid = 1'b1; alu = 32'h1000 + i; rd_addr = 5'(i); rs1_addr = 5'(i - 1);
      @(negedge clk);
      check("st_ready", {31'd0, ready}, 32'd1);
      if (i > 1) begin
        check("st_commit_valid", {31'd0, commit_valid}, 32'd1);
        check("st_wdata",  rd_wdata, 32'h1000 + i - 1);
        check("st_bypass", rs1_data, 32'h1000 + i - 1);
      end
      step();
    end
    valid = 1'b0; rs1_addr = 5'd4;
    @(negedge clk);
    check("st_commit_valid4", {31'd0, commit_valid}, 32'd1);
    check("st_bypass4", rs1_data, 32'h1004);
    step();
    rs1_addr = 5'd1; rs2_addr = 5'd3;
    @(negedge clk);
    check("st_idle",    {31'd0, commit_valid}, 32'd0);
    check("st_x1",      rs1_data, 32'h1001);
    check("st_x3",      rs2_data, 32'h1003);

    // x0 target with PC4 wrap-around.
    commit_ready = 1'b0;
    valid = 1'b1; wb_sel = 2'd2; pc = 32'hFFFFFFFC; rd_addr = 5'd0; reg_wen = 1'b1;
    rs1_addr = 5'd0;
    step();
    valid = 1'b0;
    @(negedge clk);
    check("x0_wdata",     rd_wdata, 32'h0);
    check("x0_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check("x0_commit_pc", commit_pc, 32'hFFFFFFFC);
    step();
    commit_ready = 1'b1;
    @(negedge clk);
    check("x0_read_commit", rs1_data, 32'h0);
    step();
    valid = 1'b1; pc = 32'h80000000; rd_addr = 5'd1; rs1_addr = 5'd1;
    step();
    valid = 1'b0;
    @(negedge clk);
    check("pc4_wdata", rd_wdata, 32'h80000004);
    step();
    @(negedge clk);
    check("pc4_x1", rs1_data, 32'h80000004);

    // Reset while an entry is held; reset also overrides a simultaneous commit.
    commit_ready = 1'b0;
    valid = 1'b1; wb_sel = 2'd3; csr = 32'hCAFEF00D; rd_addr = 5'd7; rs1_addr = 5'd7;
    rs2_addr = 5'd1;
    step();
    valid = 1'b0;
    @(negedge clk);
    check("rmo_held", {31'd0, commit_valid}, 32'd1);
    check("rmo_fwd",  fwd_data, 32'hCAFEF00D);
    step();
    rst_n = 1'b0; commit_ready = 1'b1;
    step();
    rst_n = 1'b1; commit_ready = 1'b0;
    @(negedge clk);
    check("rmo_commit_valid", {31'd0, commit_valid}, 32'd0);
    check("rmo_ready",        {31'd0, ready},        32'd1);
    check("rmo_x7",           rs1_data,              32'd0);
    check("rmo_x1_cleared",   rs2_data,              32'd0);
    check("rmo_wdata",        rd_wdata,              32'd0);

    // RV32E instance: write x15 and read it back.
    step();
    e_valid = 1'b1; wb_sel = 2'd0; alu = 32'h12345678; e_rd_addr = 4'd15; reg_wen = 1'b1;
    e_rs1_addr = 4'd15; e_rs2_addr = 4'd14;
    step();
    e_valid = 1'b0;
    @(negedge clk);
    check("e_fwd_addr", {28'd0, e_fwd_addr}, 32'd15);
    check("e_bypass",   e_rs1_data, 32'h12345678);
    step();
    @(negedge clk);
    check("e_x15", e_rs1_data, 32'h12345678);
    check("e_x14", e_rs2_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
